touch_confirm_ctrl: RTL and testbench

TOUCH_CONFIRM_CTRL -- requirements
Module: touch_confirm_ctrl

---
 rtl/touch_confirm_pkg.sv | 34 +++
 rtl/touch_confirm_timer.sv | 38 +++
 rtl/touch_confirm_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_touch_confirm_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_confirm_pkg.sv
// ---------------------------------------------------------------------------
// touch_confirm_pkg
// Shared definitions for the touch confirmation controller:
//   - state_t      : controller FSM states
//   - RES_*        : result codes reported on the result port
//   - STATUS_ADDR  : touch sensor status register address
//   - STATUS_BIT   : bit of the status register that flags a touch
//   - is_active()  : states in which the timeout counter and the LED blink run
// ---------------------------------------------------------------------------
package touch_confirm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WAIT  = 3'd2,
        S_POLL  = 3'd3,
        S_ACK   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_TOUCHED = 2'b01;
    localparam logic [1:0] RES_TIMEOUT = 2'b10;
    localparam logic [1:0] RES_ABORTED = 2'b11;

    localparam logic [7:0] STATUS_ADDR = 8'h09;
    localparam int         STATUS_BIT  = 0;

    // The confirmation is "waiting for a touch" in these states.
    function automatic logic is_active(input state_t s);
        return (s == S_CLEAR) || (s == S_WAIT) || (s == S_POLL);
    endfunction

endpackage

// File: rtl/touch_confirm_timer.sv
// ---------------------------------------------------------------------------
// touch_confirm_timer
// 32-bit saturating timeout counter with a latched budget.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   i_load       : clear the count and capture i_budget
//   i_enable     : advance the count by one this cycle
//   i_budget     : timeout budget (0 = never expires)
//   o_expired    : budget nonzero and count has reached it
// ---------------------------------------------------------------------------
module touch_confirm_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_enable,
    input  logic [31:0] i_budget,
    output logic        o_expired
);

    logic [31:0] r_count;
    logic [31:0] r_budget;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_budget <= '0;
        end else if (i_load) begin
            r_count  <= '0;
            r_budget <= i_budget;
        end else if (i_enable && (r_count != '1)) begin
            // Saturate instead of wrapping so a long run never "un-expires".
            r_count <= r_count + 32'd1;
        end
    end

    assign o_expired = (r_budget != '0) && (r_count >= r_budget);

endmodule

// File: rtl/touch_confirm_ctrl.sv
// ---------------------------------------------------------------------------
// touch_confirm_ctrl
// Runs one touch confirmation: clears the sensor status, polls it every
// POLL_INTERVAL idle cycles, acknowledges a touch, or gives up on timeout or
// abort. A single done pulse reports the outcome on result.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : begin / cancel a confirmation
//   timeout_cycles      : budget latched on accepted start (0 = no timeout)
//   busy, done, result  : status (01 touched, 10 timeout, 11 aborted)
//   led                 : blink while waiting for a touch
//   ts_cs, ts_we, ts_address, ts_read_data, ts_ready : sensor register bus
// Build option:
//   TOUCH_CONFIRM_BLINK_EN : when defined, led blinks with half-period
//                            BLINK_HALF; otherwise led is tied low.
// ---------------------------------------------------------------------------
module touch_confirm_ctrl
    import touch_confirm_pkg::*;
#(
    parameter int POLL_INTERVAL = 16,
    parameter int BLINK_HALF    = 1500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] timeout_cycles,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic        led,
    output logic        ts_cs,
    output logic        ts_we,
    output logic [7:0]  ts_address,
    input  logic [31:0] ts_read_data,
    input  logic        ts_ready
);

    localparam logic [15:0] WAIT_LAST = 16'(POLL_INTERVAL - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_result;
    logic [1:0]  w_result_next;
    logic [15:0] r_wait_cnt;
    logic        w_start_ok;
    logic        w_expired;
    logic        w_touched;
    logic        w_unused_rd;

    assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
    assign w_touched   = ts_read_data[STATUS_BIT];
    assign w_unused_rd = ^ts_read_data;

    touch_confirm_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_start_ok),
        .i_enable  (is_active(r_state)),
        .i_budget  (timeout_cycles),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_result <= RES_NONE;
        end else begin
            r_state  <= w_state_next;
            r_result <= w_result_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_result_next = r_result;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_next  = S_CLEAR;
                    w_result_next = RES_NONE;
                end
            end
            S_CLEAR: begin
                // Abort wins over everything; the access driven this cycle
                // still completes on the bus but nothing follows it.
                if (abort) begin
                    w_state_next  = S_DONE;
                    w_result_next = RES_ABORTED;
                end else if (ts_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_next  = S_DONE;
                    w_result_next = RES_ABORTED;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_next = S_POLL;
                end
            end
            S_POLL: begin
                if (abort) begin
                    w_state_next  = S_DONE;
                    w_result_next = RES_ABORTED;
                end else if (ts_ready) begin
                    // A touch seen on the expiring poll still counts.
                    if (w_touched) begin
                        w_state_next = S_ACK;
                    end else if (w_expired) begin
                        w_state_next  = S_DONE;
                        w_result_next = RES_TIMEOUT;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_ACK: begin
                if (abort) begin
                    w_state_next  = S_DONE;
                    w_result_next = RES_ABORTED;
                end else if (ts_ready) begin
                    w_state_next  = S_DONE;
                    w_result_next = RES_TOUCHED;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Counts idle cycles inside one WAIT visit; restarts on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_WAIT) && (w_state_next == S_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign result     = r_result;
    assign ts_cs      = (r_state == S_CLEAR) || (r_state == S_POLL) || (r_state == S_ACK);
    assign ts_we      = (r_state == S_CLEAR) || (r_state == S_ACK);
    assign ts_address = ts_cs ? STATUS_ADDR : 8'h00;

`ifdef TOUCH_CONFIRM_BLINK_EN
    localparam logic [23:0] BLINK_LAST = 24'(BLINK_HALF - 1);

    logic        r_led;
    logic [23:0] r_blink_cnt;

    // Decided on the next state so led is already high in the first CLEAR
    // cycle and already low in the first cycle after leaving the wait states.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led       <= 1'b0;
            r_blink_cnt <= '0;
        end else if (is_active(w_state_next)) begin
            if (!is_active(r_state)) begin
                r_led       <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == BLINK_LAST) begin
                r_led       <= ~r_led;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 24'd1;
            end
        end else begin
            r_led       <= 1'b0;
            r_blink_cnt <= '0;
        end
    end

    assign led = r_led;
`else
    logic [23:0] w_unused_blink;
    assign w_unused_blink = 24'(BLINK_HALF);
    assign led            = 1'b0;
`endif

endmodule

// File: tb/tb_touch_confirm_ctrl.sv
module tb_touch_confirm_ctrl;

    localparam int PI = 4;
    localparam int BH = 3;
`ifdef TOUCH_CONFIRM_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] timeout_cycles = '0;
    logic        busy, done, led, ts_cs, ts_we, ts_ready;
    logic [1:0]  result;
    logic [7:0]  ts_address;
    logic [31:0] ts_read_data;

    int          cyc = 0;
    int          touch_at = 32'h4000_0000;
    logic [30:0] rd_junk = '0;

    assign ts_ready     = ts_cs;
    assign ts_read_data = {rd_junk, (cyc >= touch_at)};

    touch_confirm_ctrl #(.POLL_INTERVAL(PI), .BLINK_HALF(BH)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .timeout_cycles(timeout_cycles), .busy(busy), .done(done),
        .result(result), .led(led), .ts_cs(ts_cs), .ts_we(ts_we),
        .ts_address(ts_address), .ts_read_data(ts_read_data), .ts_ready(ts_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model: one transaction timeline ----------
    int         m_s = -10, m_done = -5, m_last_poll = -10, m_ack = -1, m_act_end = -10;
    logic [1:0] m_res = 2'b00, m_prev = 2'b00;
    bit         model_en = 1'b0;

    function automatic bit m_poll(input int c);
        return (c > m_s + 1) && (c <= m_last_poll) && (((c - m_s - 1) % (PI + 1)) == 0);
    endfunction

    // Polls fall every PI+1 cycles after the clear write; the first poll that
    // sees a touch, or exceeds the budget, or an earlier abort ends the run.
    task automatic plan(input int s, input int t_at, input int tmo, input int a);
        bit found = 1'b0;
        m_prev = m_res;
        m_s    = s;
        m_ack  = -1;
        for (int n = 1; n <= 1000 && !found; n++) begin
            int p = s + 1 + n * (PI + 1);
            if (a >= 0 && a <= p) begin
                m_done = a + 1; m_res = 2'b11; m_act_end = a;
                m_last_poll = (a == p) ? p : p - (PI + 1);
                found = 1'b1;
            end else if (p >= t_at) begin
                m_ack = p + 1; m_done = p + 2; m_res = 2'b01;
                m_last_poll = p; m_act_end = p; found = 1'b1;
            end else if (tmo != 0 && (p - s - 1) >= tmo) begin
                m_done = p + 1; m_res = 2'b10;
                m_last_poll = p; m_act_end = p; found = 1'b1;
            end
        end
    endtask

    function automatic logic [13:0] m_expect(input int c);
        logic b, d, l, cs, we;
        logic [1:0] r;
        b = 0; d = 0; l = 0; cs = 0; we = 0;
        if (c <= m_s) begin
            r = m_prev;
        end else if (c <= m_done) begin
            b  = 1;
            d  = (c == m_done);
            r  = d ? m_res : 2'b00;
            cs = (c == m_s + 1) || m_poll(c) || (c == m_ack);
            we = (c == m_s + 1) || (c == m_ack);
            l  = BLINK_EN && (c <= m_act_end) && ((((c - m_s - 1) / BH) % 2) == 0);
        end else begin
            r = m_res;
        end
        return {b, d, r, l, cs, we, (cs ? 8'h09 : 8'h00)};
    endfunction

    always @(posedge clk) begin
        #1;
        if (model_en) begin
            logic [13:0] exp_v, got_v;
            exp_v = m_expect(cyc);
            got_v = {busy, done, result, led, ts_cs, ts_we, ts_address};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_model cyc=%0d {busy,done,result,led,cs,we,addr}: got %b required %b",
                         cyc, got_v, exp_v);
            end
        end
    end

    // ---------------- monitor -----------------------------------------------
    int n_wr = 0, n_rd = 0, n_done = 0, last_done = -1, first_rd = -1;
    always @(posedge clk) begin
        #1;
        if (done) begin n_done++; last_done = cyc; end
        if (ts_cs && ts_we) n_wr++;
        if (ts_cs && !ts_we) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // One confirmation; *_rel values are cycles after the start cycle (-1 = none).
    task automatic run(input string name, input int touch_rel, input int tmo,
                       input int abort_rel, input int busy_start_rel,
                       output int done_rel, output int rd_rel);
        int s;
        @(negedge clk);
        n_wr = 0; n_rd = 0; n_done = 0; last_done = -1; first_rd = -1;
        s = cyc;
        touch_at = (touch_rel < 0) ? 32'h4000_0000 : s + touch_rel;
        plan(s, touch_at, tmo, (abort_rel < 0) ? -1 : s + abort_rel);
        start = 1'b1;
        timeout_cycles = tmo;
        @(negedge clk);
        start = 1'b0;
        timeout_cycles = 32'd3;   // must have no effect once latched
        for (int k = 0; k < 3000 && cyc <= m_done + 2; k++) begin
            abort   = ((cyc - s) == abort_rel);
            start   = ((cyc - s) == busy_start_rel);
            rd_junk = 31'($urandom);
            @(negedge clk);
        end
        abort = 1'b0; start = 1'b0;
        check({name, "_done_count"}, n_done, 1);
        done_rel = (last_done < 0) ? -1 : last_done - s;
        rd_rel   = (first_rd < 0) ? -1 : first_rd - s;
        $display("txn %s: done at +%0d result=%b writes=%0d reads=%0d first_read=+%0d",
                 name, done_rel, result, n_wr, n_rd, rd_rel);
    endtask

    initial begin
        int dr, rr;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_outputs", {done, result, led, ts_cs, ts_we, ts_address}, 0);
        reset = 1'b0;
        @(negedge clk);
        model_en = 1'b1;

        // touch appears between poll 1 (+6) and poll 2 (+11); stray start in WAIT
        run("touch_poll2", 7, 0, -1, 3, dr, rr);
        check("touch_poll2_model_done", m_done - m_s, 13);
        check("touch_poll2_done_rel", dr, 13);
        check("touch_poll2_result", result, 1);
        check("touch_poll2_first_read", rr, 6);
        check("touch_poll2_writes", n_wr, 2);
        check("touch_poll2_reads", n_rd, 2);

        // polls at +6,+11,+16,+21; count at +21 is 20 -> timeout
        run("timeout20", -1, 20, -1, -1, dr, rr);
        check("timeout20_done_rel", dr, 22);
        check("timeout20_result", result, 2);
        check("timeout20_no_ack_write", n_wr, 1);
        check("timeout20_reads", n_rd, 4);

        run("abort_wait", -1, 0, 3, -1, dr, rr);
        check("abort_wait_done_rel", dr, 4);
        check("abort_wait_result", result, 3);
        check("abort_wait_reads", n_rd, 0);

        run("abort_poll", -1, 0, 6, -1, dr, rr);
        check("abort_poll_done_rel", dr, 7);
        check("abort_poll_reads", n_rd, 1);

        // no budget: first poll at/after +500 is +501
        run("no_timeout", 500, 0, -1, -1, dr, rr);
        check("no_timeout_done_rel", dr, 503);
        check("no_timeout_result", result, 1);

        // touch on the very poll where the budget expires
        run("touch_vs_timeout", 21, 20, -1, -1, dr, rr);
        check("touch_vs_timeout_done_rel", dr, 23);
        check("touch_vs_timeout_result", result, 1);

        // start together with abort in IDLE is ignored
        @(negedge clk);
        n_done = 0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (8) @(negedge clk);
        check("start_abort_idle_busy", busy, 0);
        check("start_abort_idle_done", n_done, 0);
        check("start_abort_idle_result", result, 1);
        $display("txn start_abort_idle: done pulses=%0d busy=%b", n_done, busy);

        // reset while a poll is on the bus
        model_en = 1'b0;
        touch_at = 32'h4000_0000;
        start = 1'b1;
        timeout_cycles = 0;
        @(negedge clk);
        start = 1'b0;
        begin
            int k = 0;
            while (!(ts_cs && !ts_we) && k < 50) begin @(negedge clk); k++; end
            check("reset_poll_reached", k < 50, 1);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_poll_busy", busy, 0);
        check("reset_mid_poll_outputs", {done, result, led, ts_cs, ts_we, ts_address}, 0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        m_s = -10; m_done = -5; m_res = 2'b00; m_prev = 2'b00;
        model_en = 1'b1;
        repeat (20) @(negedge clk);
        check("reset_mid_poll_no_done", n_done, 0);
        $display("txn reset_mid_poll: done pulses after reset=%0d", n_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
